alu_result_collector: RTL and testbench

- Downstream stage of the 16-bit ALU top.
- Consumes the four registered ALU result buses and their per-unit valid flags (Arith/Logic/CMP/Shift).
- Normalises each result into one tagged result word and buffers it in a small first-word-fall-through FIFO.
- The FIFO drains to a consumer over a valid/ready handshake, with sticky error reporting for overflow and malformed flag patterns.

---
 rtl/alu_result_collector.sv | 153 +++++++++++++++
 tb/tb_alu_result_collector.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_collector.sv
// Collects the four ALU result buses into tagged words and buffers them in a FWFT FIFO.
// Latency: one edge from a single valid flag to RES_VALID/RES_DATA at the head.
// Backpressure: RES_READY stalls the head; when full, a capture is accepted only alongside a pop, otherwise dropped and counted.

module fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             rd_fire;
    logic             wr_fire;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld  = !empty;
    assign rd_fire = rd_vld && rd_rdy;
    assign wr_rdy  = !full || rd_fire;
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A write into a full FIFO lands in the slot the head vacates this edge.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module alu_result_collector #(
    parameter int OP_DATA_WIDTH = 16,
    parameter int CMP_OUT_WIDTH = 3,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [2*OP_DATA_WIDTH-1:0]    Arith_OUT,
    input  logic                          Arith_Flag,
    input  logic [OP_DATA_WIDTH-1:0]      Logic_OUT,
    input  logic                          Logic_Flag,
    input  logic [CMP_OUT_WIDTH-1:0]      CMP_OUT,
    input  logic                          CMP_Flag,
    input  logic [OP_DATA_WIDTH-1:0]      Shift_OUT,
    input  logic                          Shift_Flag,
    input  logic                          RES_READY,
    input  logic                          CLR_ERR,
    output logic                          RES_VALID,
    output logic [2*OP_DATA_WIDTH-1:0]    RES_DATA,
    output logic [1:0]                    RES_SRC,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          OVERFLOW_ERR,
    output logic                          MULTI_FLAG_ERR,
    output logic [7:0]                    DROP_CNT
);
    localparam int RW = 2 * OP_DATA_WIDTH;

    typedef struct packed {
        logic [1:0]    src;
        logic [RW-1:0] data;
    } res_t;

    res_t       cap_dat;
    res_t       head_dat;
    logic [2:0] flag_cnt;
    logic       cap_vld;
    logic       multi_hit;
    logic       ovf_drop;
    logic       drop;
    logic       fifo_wr_rdy;

    assign flag_cnt  = 3'(Arith_Flag) + 3'(Logic_Flag) + 3'(CMP_Flag) + 3'(Shift_Flag);
    assign cap_vld   = (flag_cnt == 3'd1);
    assign multi_hit = (flag_cnt > 3'd1);
    assign ovf_drop  = cap_vld && !fifo_wr_rdy;
    assign drop      = multi_hit || ovf_drop;

    always_comb begin
        cap_dat = '0;
        if (Arith_Flag) begin
            cap_dat.src  = 2'b00;
            cap_dat.data = Arith_OUT;
        end else if (Logic_Flag) begin
            cap_dat.src  = 2'b01;
            cap_dat.data = {{(RW-OP_DATA_WIDTH){1'b0}}, Logic_OUT};
        end else if (CMP_Flag) begin
            cap_dat.src  = 2'b10;
            cap_dat.data = {{(RW-CMP_OUT_WIDTH){1'b0}}, CMP_OUT};
        end else if (Shift_Flag) begin
            cap_dat.src  = 2'b11;
            cap_dat.data = {{(RW-OP_DATA_WIDTH){1'b0}}, Shift_OUT};
        end
    end

    fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_vld (cap_vld),
        .wr_dat (cap_dat),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (RES_VALID),
        .rd_dat (head_dat),
        .rd_rdy (RES_READY),
        .count  (FIFO_COUNT)
    );

    assign RES_DATA = head_dat.data;
    assign RES_SRC  = head_dat.src;

    // A drop in the clearing cycle survives the clear and restarts the count at 1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW_ERR   <= 1'b0;
            MULTI_FLAG_ERR <= 1'b0;
            DROP_CNT       <= 8'd0;
        end else if (CLR_ERR) begin
            OVERFLOW_ERR   <= ovf_drop;
            MULTI_FLAG_ERR <= multi_hit;
            DROP_CNT       <= drop ? 8'd1 : 8'd0;
        end else begin
            if (ovf_drop)  OVERFLOW_ERR   <= 1'b1;
            if (multi_hit) MULTI_FLAG_ERR <= 1'b1;
            if (drop && (DROP_CNT != 8'hFF)) DROP_CNT <= DROP_CNT + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_result_collector.sv
// Randomised bench for alu_result_collector against a queue-based reference model.
module tb_alu_result_collector;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Arith_OUT;
    logic        Arith_Flag;
    logic [15:0] Logic_OUT;
    logic        Logic_Flag;
    logic [2:0]  CMP_OUT;
    logic        CMP_Flag;
    logic [15:0] Shift_OUT;
    logic        Shift_Flag;
    logic        RES_READY;
    logic        CLR_ERR;
    logic        RES_VALID;
    logic [31:0] RES_DATA;
    logic [1:0]  RES_SRC;
    logic [3:0]  FIFO_COUNT;
    logic        OVERFLOW_ERR;
    logic        MULTI_FLAG_ERR;
    logic [7:0]  DROP_CNT;

    int checks = 0;
    int errors = 0;

    logic [33:0] q[$];
    bit          m_ovf;
    bit          m_multi;
    int          m_drop;

    alu_result_collector dut (
        .CLK(CLK), .RST(RST),
        .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
        .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
        .RES_READY(RES_READY), .CLR_ERR(CLR_ERR),
        .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_SRC(RES_SRC),
        .FIFO_COUNT(FIFO_COUNT), .OVERFLOW_ERR(OVERFLOW_ERR),
        .MULTI_FLAG_ERR(MULTI_FLAG_ERR), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [48:0] dut_vec();
        return {RES_VALID, RES_SRC, RES_DATA, FIFO_COUNT, OVERFLOW_ERR, MULTI_FLAG_ERR, DROP_CNT};
    endfunction

    function automatic logic [48:0] exp_vec();
        logic [33:0] h;
        h = (q.size() != 0) ? q[0] : 34'd0;
        return {q.size() != 0, h, 4'(q.size()), m_ovf, m_multi, 8'(m_drop)};
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf = 0; m_multi = 0; m_drop = 0;
    endtask

    task automatic model_count_drop();
        if (m_drop < 255) m_drop++;
    endtask

    // Applies one rising edge's worth of behaviour using the inputs currently driven.
    task automatic model_edge();
        int n;
        bit pop;
        bit push;
        logic [33:0] e;
        if (RST) begin
            model_clear();
            return;
        end
        n = int'(Arith_Flag) + int'(Logic_Flag) + int'(CMP_Flag) + int'(Shift_Flag);
        pop = (q.size() > 0) && RES_READY;
        push = 0;
        e = '0;
        if (CLR_ERR) begin
            m_ovf = 0; m_multi = 0; m_drop = 0;
        end
        if (n > 1) begin
            m_multi = 1;
            model_count_drop();
        end else if (n == 1) begin
            if (Arith_Flag)      e = {2'b00, Arith_OUT};
            else if (Logic_Flag) e = {2'b01, 32'(Logic_OUT)};
            else if (CMP_Flag)   e = {2'b10, 32'(CMP_OUT)};
            else                 e = {2'b11, 32'(Shift_OUT)};
            if (q.size() < 8 || pop) push = 1;
            else begin
                m_ovf = 1;
                model_count_drop();
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
    endtask

    task automatic drive_one(input int kind, input logic [31:0] v);
        idle();
        Arith_OUT = $urandom; Logic_OUT = 16'($urandom);
        CMP_OUT = 3'($urandom); Shift_OUT = 16'($urandom);
        case (kind)
            0: begin Arith_Flag = 1; Arith_OUT = v; end
            1: begin Logic_Flag = 1; Logic_OUT = v[15:0]; end
            2: begin CMP_Flag = 1; CMP_OUT = v[2:0]; end
            default: begin Shift_Flag = 1; Shift_OUT = v[15:0]; end
        endcase
    endtask

    task automatic test_reset();
        RST = 1; RES_READY = 0; CLR_ERR = 0; idle();
        Arith_OUT = 0; Logic_OUT = 0; CMP_OUT = 0; Shift_OUT = 0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (dut_vec() !== 49'd0) begin
            errors++;
            $display("FAIL reset_state: actual=%h required=0", dut_vec());
        end
        RST = 0;
        model_clear();
    endtask

    task automatic test_arith_single();
        RES_READY = 0;
        drive_one(0, 32'hFFFF_FFF3);
        cycle();
        idle();
        checks++;
        if ({RES_VALID, RES_SRC, RES_DATA, FIFO_COUNT} !== {1'b1, 2'b00, 32'hFFFF_FFF3, 4'd1}) begin
            errors++;
            $display("FAIL arith_head: actual v=%b src=%b data=%h cnt=%0d required v=1 src=00 data=fffffff3 cnt=1",
                     RES_VALID, RES_SRC, RES_DATA, FIFO_COUNT);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (RES_VALID !== 1'b1 || RES_DATA !== 32'hFFFF_FFF3 || RES_SRC !== 2'b00) begin
                errors++;
                $display("FAIL arith_hold: actual v=%b data=%h src=%b required v=1 data=fffffff3 src=00",
                         RES_VALID, RES_DATA, RES_SRC);
            end
        end
        RES_READY = 1;
        cycle();
        RES_READY = 0;
        checks++;
        if (RES_VALID !== 1'b0 || RES_DATA !== 32'd0 || FIFO_COUNT !== 4'd0) begin
            errors++;
            $display("FAIL arith_pop: actual v=%b data=%h cnt=%0d required v=0 data=0 cnt=0",
                     RES_VALID, RES_DATA, FIFO_COUNT);
        end
    endtask

    task automatic test_sources_order();
        logic [33:0] exp_t [3];
        exp_t[0] = {2'b01, 32'h0000_0001};
        exp_t[1] = {2'b10, 32'h0000_0002};
        exp_t[2] = {2'b11, 32'h0000_FFFC};
        RES_READY = 0;
        drive_one(1, 32'h0001); cycle();
        drive_one(2, 32'h0002); cycle();
        drive_one(3, 32'hFFFC); cycle();
        idle();
        checks++;
        if (FIFO_COUNT !== 4'd3) begin
            errors++;
            $display("FAIL src_count: actual=%0d required=3", FIFO_COUNT);
        end
        RES_READY = 1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({RES_VALID, RES_SRC, RES_DATA} !== {1'b1, exp_t[i]}) begin
                errors++;
                $display("FAIL src_drain%0d: actual v=%b src=%b data=%h required v=1 src/data=%h",
                         i, RES_VALID, RES_SRC, RES_DATA, exp_t[i]);
            end
            cycle();
        end
        RES_READY = 0;
        checks++;
        if (RES_VALID !== 1'b0) begin
            errors++;
            $display("FAIL src_empty: actual v=%b required v=0", RES_VALID);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] vals [8];
        logic [31:0] v10;
        RES_READY = 0;
        for (int i = 0; i < 8; i++) begin
            vals[i] = $urandom;
            drive_one(0, vals[i]);
            cycle();
        end
        drive_one(0, 32'hDEAD_0009);
        cycle();
        idle();
        checks++;
        if ({FIFO_COUNT, OVERFLOW_ERR, DROP_CNT} !== {4'd8, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ovf_drop: actual cnt=%0d ovf=%b drop=%0d required cnt=8 ovf=1 drop=1",
                     FIFO_COUNT, OVERFLOW_ERR, DROP_CNT);
        end
        v10 = $urandom;
        drive_one(0, v10);
        RES_READY = 1;
        cycle();
        RES_READY = 0;
        idle();
        checks++;
        if (FIFO_COUNT !== 4'd8 || DROP_CNT !== 8'd1) begin
            errors++;
            $display("FAIL ovf_full_pop_write: actual cnt=%0d drop=%0d required cnt=8 drop=1",
                     FIFO_COUNT, DROP_CNT);
        end
        RES_READY = 1;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (RES_DATA !== ((i == 8) ? v10 : vals[i]) || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_drain%0d: actual=%h required=%h data_req=%h",
                         i, dut_vec(), exp_vec(), (i == 8) ? v10 : vals[i]);
            end
            cycle();
        end
        RES_READY = 0;
    endtask

    task automatic test_multi_flag();
        RES_READY = 0;
        drive_one(0, 32'h1234_5678);
        cycle();
        Arith_Flag = 1; Logic_Flag = 1;
        cycle();
        idle();
        checks++;
        if (MULTI_FLAG_ERR !== 1'b1 || DROP_CNT !== 8'd2 || FIFO_COUNT !== 4'd1) begin
            errors++;
            $display("FAIL multi_set: actual multi=%b drop=%0d cnt=%0d required multi=1 drop=2 cnt=1",
                     MULTI_FLAG_ERR, DROP_CNT, FIFO_COUNT);
        end
        CLR_ERR = 1;
        cycle();
        CLR_ERR = 0;
        checks++;
        if ({OVERFLOW_ERR, MULTI_FLAG_ERR, DROP_CNT} !== 10'd0 || FIFO_COUNT !== 4'd1
            || RES_DATA !== 32'h1234_5678) begin
            errors++;
            $display("FAIL clr_alone: actual ovf=%b multi=%b drop=%0d cnt=%0d data=%h required 0 0 0 1 12345678",
                     OVERFLOW_ERR, MULTI_FLAG_ERR, DROP_CNT, FIFO_COUNT, RES_DATA);
        end
        cycle();
        CLR_ERR = 1; CMP_Flag = 1; Shift_Flag = 1;
        cycle();
        CLR_ERR = 0; idle();
        checks++;
        if ({OVERFLOW_ERR, MULTI_FLAG_ERR, DROP_CNT} !== {1'b0, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL clr_with_event: actual ovf=%b multi=%b drop=%0d required ovf=0 multi=1 drop=1",
                     OVERFLOW_ERR, MULTI_FLAG_ERR, DROP_CNT);
        end
        RES_READY = 1;
        cycle();
        RES_READY = 0;
    endtask

    task automatic test_saturate();
        Arith_Flag = 1; Shift_Flag = 1;
        repeat (260) cycle();
        idle();
        checks++;
        if (DROP_CNT !== 8'd255 || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL drop_saturate: actual drop=%0d vec=%h required drop=255 vec=%h",
                     DROP_CNT, dut_vec(), exp_vec());
        end
        CLR_ERR = 1;
        cycle();
        CLR_ERR = 0;
    endtask

    task automatic test_stream();
        int bad = 0;
        RES_READY = 1;
        for (int i = 0; i < 20; i++) begin
            drive_one(int'($urandom_range(0, 3)), $urandom);
            cycle();
            checks++;
            if (FIFO_COUNT > 4'd1 || OVERFLOW_ERR !== 1'b0 || MULTI_FLAG_ERR !== 1'b0
                || dut_vec() !== exp_vec()) begin
                errors++; bad++;
                $display("FAIL stream%0d: actual=%h required=%h (count must stay <=1)",
                         i, dut_vec(), exp_vec());
            end
        end
        idle();
        cycle();
        RES_READY = 0;
        checks++;
        if (RES_VALID !== 1'b0 || DROP_CNT !== 8'd0) begin
            errors++;
            $display("FAIL stream_end: actual v=%b drop=%0d required v=0 drop=0", RES_VALID, DROP_CNT);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 2) idle();
            else if (r < 9) drive_one(int'($urandom_range(0, 3)), $urandom);
            else begin
                drive_one(0, $urandom);
                Logic_Flag = 1; CMP_Flag = 1'($urandom);
            end
            RES_READY = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            CLR_ERR = ($urandom_range(0, 40) == 0);
            cycle();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random%0d: actual=%h required=%h", i, dut_vec(), exp_vec());
            end
        end
        idle(); CLR_ERR = 0; RES_READY = 0;
    endtask

    task automatic test_reset_midburst();
        RES_READY = 1;
        cycle();
        RES_READY = 0;
        for (int i = 0; i < 5; i++) begin
            drive_one(int'($urandom_range(0, 3)), $urandom);
            cycle();
        end
        idle();
        RES_READY = 1;
        checks++;
        if (FIFO_COUNT !== 4'(q.size())) begin
            errors++;
            $display("FAIL pre_reset_count: actual=%0d required=%0d", FIFO_COUNT, q.size());
        end
        #2 RST = 1;
        #1;
        model_clear();
        checks++;
        if (dut_vec() !== 49'd0) begin
            errors++;
            $display("FAIL async_reset: actual=%h required=0", dut_vec());
        end
        @(posedge CLK);
        #3 RST = 0;
        drive_one(1, 32'h0000_A5A5);
        cycle();
        idle();
        checks++;
        if ({RES_VALID, RES_SRC, RES_DATA, FIFO_COUNT} !== {1'b1, 2'b01, 32'h0000_A5A5, 4'd1}) begin
            errors++;
            $display("FAIL post_reset_head: actual v=%b src=%b data=%h cnt=%0d required v=1 src=01 data=0000a5a5 cnt=1",
                     RES_VALID, RES_SRC, RES_DATA, FIFO_COUNT);
        end
    endtask

    initial begin
        test_reset();
        test_arith_single();
        test_sources_order();
        test_overflow();
        test_multi_flag();
        test_saturate();
        test_stream();
        test_back_to_back();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
